// File: rtl/alu_sequencer_pkg.sv
// Shared widths, instruction layout, opcodes and FSM states for the ALU sequencer.
package alu_sequencer_pkg;

  localparam int unsigned DATA_W  = 4;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned INSTR_W = OP_W + 3 * ADDR_W;

  // Instruction field bit positions: [14:12] op, [11:8] dst, [7:4] srcA, [3:0] srcB/imm
  localparam int unsigned OP_MSB   = 14;
  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned DST_MSB  = 11;
  localparam int unsigned DST_LSB  = 8;
  localparam int unsigned SRCA_MSB = 7;
  localparam int unsigned SRCA_LSB = 4;
  localparam int unsigned SRCB_MSB = 3;
  localparam int unsigned SRCB_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_LDI = 3'b000,
    OP_SUB = 3'b001,
    OP_ADD = 3'b010
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_ERR
  } state_e;

  // Latched instruction; src_b doubles as the LDI immediate
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
  } instr_t;

  // Opcodes this stage executes; ascend/descend belong elsewhere
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_LDI, OP_SUB, OP_ADD: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU drive/return and debug read port of the sequencer.
interface alu_sequencer_if
  import alu_sequencer_pkg::*;
  ;
  logic                instr_valid;
  logic [INSTR_W-1:0]  instr;
  logic                instr_ready;
  logic [OP_W-1:0]     alu_op;
  logic [DATA_W-1:0]   alu_v1;
  logic [DATA_W-1:0]   alu_v2;
  logic [DATA_W-1:0]   alu_out;
  logic                done;
  logic                illegal;
  logic [ADDR_W-1:0]   dbg_addr;
  logic [DATA_W-1:0]   dbg_data;

  // Environment side: issues instructions, hosts the ALU, reads the debug port
  modport master (
    output instr_valid, instr, alu_out, dbg_addr,
    input  instr_ready, alu_op, alu_v1, alu_v2, done, illegal, dbg_data
  );

  // Sequencer side
  modport slave (
    input  instr_valid, instr, alu_out, dbg_addr,
    output instr_ready, alu_op, alu_v1, alu_v2, done, illegal, dbg_data
  );
endinterface

// File: rtl/alu_sequencer_reg_file.sv
// DEPTH x DATA_W register file: two operand read ports, one debug read port, one write port.
module alu_sequencer_reg_file #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage: cleared asynchronously, written on the clock edge when enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = mem_q[raddr_a_i];
  assign rdata_b_o  = mem_q[raddr_b_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Control stage for the external 4-bit ALU: accept, read operands, execute, write back.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.slave bus
);

  state_e            state_q;
  instr_t            fields_q;
  instr_t            fields_d;
  logic [DATA_W-1:0] result_q;
  logic              instr_ready_q;
  logic              done_q;
  logic              illegal_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [DATA_W-1:0] alu_v1_q;
  logic [DATA_W-1:0] alu_v2_q;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              rf_we_c;

  // Split the incoming instruction word into its fields
  always_comb begin
    fields_d       = '0;
    fields_d.op    = bus.instr[OP_MSB:OP_LSB];
    fields_d.dst   = bus.instr[DST_MSB:DST_LSB];
    fields_d.src_a = bus.instr[SRCA_MSB:SRCA_LSB];
    fields_d.src_b = bus.instr[SRCB_MSB:SRCB_LSB];
  end

  // Write-back happens on the edge that leaves WRITE
  assign rf_we_c = (state_q == S_WRITE);

  alu_sequencer_reg_file #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_reg_file (
    .clk        (clk),
    .reset      (reset),
    .we_i       (rf_we_c),
    .waddr_i    (fields_q.dst),
    .wdata_i    (result_q),
    .raddr_a_i  (fields_q.src_a),
    .rdata_a_o  (rd_a),
    .raddr_b_i  (fields_q.src_b),
    .rdata_b_o  (rd_b),
    .dbg_addr_i (bus.dbg_addr),
    .dbg_data_o (bus.dbg_data)
  );

  // Sequencer FSM; every output is registered alongside the state transition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      fields_q      <= '0;
      result_q      <= '0;
      instr_ready_q <= 1'b1;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      alu_op_q      <= '0;
      alu_v1_q      <= '0;
      alu_v2_q      <= '0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.instr_valid) begin
            fields_q      <= fields_d;
            instr_ready_q <= 1'b0;
            if (op_is_legal(fields_d.op)) begin
              state_q <= S_READ;
            end else begin
              state_q   <= S_ERR;
              illegal_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          alu_v1_q <= rd_a;
          alu_v2_q <= rd_b;
          alu_op_q <= fields_q.op;
          state_q  <= S_EXEC;
        end
        S_EXEC: begin
          result_q <= (fields_q.op == OP_LDI) ? DATA_W'(fields_q.src_b) : bus.alu_out;
          alu_op_q <= '0;
          done_q   <= 1'b1;
          state_q  <= S_WRITE;
        end
        S_WRITE: begin
          instr_ready_q <= 1'b1;
          state_q       <= S_IDLE;
        end
        S_ERR: begin
          instr_ready_q <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: begin
          instr_ready_q <= 1'b1;
          alu_op_q      <= '0;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_v1      = alu_v1_q;
  assign bus.alu_v2      = alu_v2_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised scoreboard bench for alu_sequencer with an in-bench ALU and register-file model.
module tb_alu_sequencer;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_err;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] op;
    logic [3:0] dst;
    logic [3:0] a_val;
    logic [3:0] b_val;
    logic [3:0] res;
    int         acc;
  } exp_t;

  exp_t       q[$];
  logic [3:0] mdl[16];
  bit         pend_v;
  logic [3:0] pend_dst;
  logic [3:0] pend_val;
  int         sweep_req;
  int         sweep_ack;

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // External 4-bit ALU: 001 -> v2 - v1, 010 -> v1 + v2
  always_comb begin
    case (bus.alu_op)
      3'b001:  bus.alu_out = 4'(bus.alu_v2 - bus.alu_v1);
      3'b010:  bus.alu_out = 4'(bus.alu_v1 + bus.alu_v2);
      default: bus.alu_out = 4'd0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Present one instruction and wait (bounded) for it to be accepted
  task automatic issue(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] a,
                       input logic [3:0] b, input bit hold, output int acc);
    exp_t e;
    int   waited;
    waited = 0;
    acc    = -1;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = {op, dst, a, b};
    while (!bus.instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_timeout", 32'(waited < 20), 32'd1);
    if (waited >= 20) begin
      bus.instr_valid = 1'b0;
      return;
    end
    e.op    = op;
    e.dst   = dst;
    e.a_val = mdl[a];
    e.b_val = mdl[b];
    case (op)
      3'd0:    e.res = b;
      3'd1:    e.res = 4'((int'(mdl[b]) - int'(mdl[a])) % 16);
      3'd2:    e.res = 4'((int'(mdl[a]) + int'(mdl[b])) % 16);
      default: e.res = 4'd0;
    endcase
    e.acc = cyc + 1;
    acc   = e.acc;
    q.push_back(e);
    if (op <= 3'd2) mdl[dst] = e.res;
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.instr       = 15'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || pend_v) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 40), 32'd1);
    @(negedge clk);
  endtask

  task automatic sweep();
    int n;
    n = 0;
    sweep_req++;
    while (sweep_ack != sweep_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("sweep_timeout", 32'(sweep_ack == sweep_req), 32'd1);
  endtask

  // Monitor: pops the scoreboard as outputs appear and checks them against the model
  initial begin
    exp_t e;
    int   k;
    bit   legal;
    bus.dbg_addr = '0;
    pend_v       = 1'b0;
    sweep_ack    = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend_v = 1'b0;
      end else begin
        if (pend_v) begin
          bus.dbg_addr = pend_dst;
          #1;
          check("writeback_dbg", 32'(bus.dbg_data), 32'(pend_val));
          pend_v = 1'b0;
        end
        if (q.size() > 0 && cyc >= q[0].acc) begin
          e     = q[0];
          k     = cyc - e.acc;
          legal = (e.op <= 3'd2);
          check("ready_busy", 32'(bus.instr_ready), 32'd0);
          check("alu_op", 32'(bus.alu_op), (legal && k == 1) ? 32'(e.op) : 32'd0);
          check("done", 32'(bus.done), 32'(legal && k == 2));
          check("illegal", 32'(bus.illegal), 32'(!legal && k == 0));
          if (legal && k == 1 && e.op != 3'd0) begin
            check("alu_v1", 32'(bus.alu_v1), 32'(e.a_val));
            check("alu_v2", 32'(bus.alu_v2), 32'(e.b_val));
          end
          if ((legal && k >= 2) || (!legal && k >= 0)) begin
            void'(q.pop_front());
            if (legal) begin
              pend_v   = 1'b1;
              pend_dst = e.dst;
              pend_val = e.res;
            end
          end
        end else begin
          check("ready_idle", 32'(bus.instr_ready), 32'd1);
          check("alu_op_idle", 32'(bus.alu_op), 32'd0);
          check("done_idle", 32'(bus.done), 32'd0);
          check("illegal_idle", 32'(bus.illegal), 32'd0);
        end
        if (sweep_ack != sweep_req && q.size() == 0 && !pend_v) begin
          for (int i = 0; i < 16; i++) begin
            bus.dbg_addr = 4'(i);
            #1;
            check("regfile_sweep", 32'(bus.dbg_data), 32'(mdl[i]));
          end
          sweep_ack++;
        end
      end
    end
  end

  initial begin
    int a0, a1, a2, acc, n;
    logic [2:0] op;
    int r;
    n_cmp           = 0;
    n_err           = 0;
    sweep_req       = 0;
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    for (int i = 0; i < 16; i++) mdl[i] = 4'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_v1", 32'(bus.alu_v1), 32'd0);
    check("rst_v2", 32'(bus.alu_v2), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    reset = 1'b0;
    sweep();

    // Directed: loads, SUB wrap, ADD with dst==srcA, illegal opcode
    issue(3'd0, 4'd1, 4'd0, 4'd3, 1'b0, acc);
    issue(3'd0, 4'd2, 4'd0, 4'd5, 1'b0, acc);
    issue(3'd1, 4'd4, 4'd2, 4'd1, 1'b0, acc);
    issue(3'd0, 4'd1, 4'd0, 4'd9, 1'b0, acc);
    issue(3'd0, 4'd2, 4'd0, 4'd8, 1'b0, acc);
    issue(3'd2, 4'd1, 4'd1, 4'd2, 1'b0, acc);
    issue(3'd3, 4'd5, 4'd1, 4'd2, 1'b0, acc);
    issue(3'd1, 4'd6, 4'd4, 4'd4, 1'b0, acc);
    wait_idle();
    check("r4_sub_wrap", 32'(mdl[4]), 32'hE);
    check("r1_add_wrap", 32'(mdl[1]), 32'h1);
    sweep();

    // Back-to-back with instr_valid held high
    issue(3'd0, 4'd7, 4'd0, 4'd10, 1'b1, a0);
    issue(3'd0, 4'd8, 4'd0, 4'd11, 1'b1, a1);
    issue(3'd0, 4'd9, 4'd0, 4'd12, 1'b0, a2);
    check("burst_spacing_1", 32'(a1 - a0), 32'd4);
    check("burst_spacing_2", 32'(a2 - a1), 32'd4);
    wait_idle();
    sweep();

    // Reset during EXEC of an ADD
    issue(3'd0, 4'd3, 4'd0, 4'd6, 1'b0, acc);
    issue(3'd2, 4'd5, 4'd3, 4'd3, 1'b0, acc);
    n = 0;
    while (bus.alu_op != 3'b010 && n < 6) begin
      @(negedge clk);
      n++;
    end
    check("reached_exec", 32'(bus.alu_op), 32'd2);
    #2;
    reset = 1'b1;
    q.delete();
    for (int i = 0; i < 16; i++) mdl[i] = 4'd0;
    @(negedge clk);
    check("midrst_ready", 32'(bus.instr_ready), 32'd1);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_alu_op", 32'(bus.alu_op), 32'd0);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("postrst_done", 32'(bus.done), 32'd0);
    check("postrst_ready", 32'(bus.instr_ready), 32'd1);
    sweep();

    // Random traffic
    for (int i = 0; i < 16; i++) issue(3'd0, 4'(i), 4'($urandom), 4'($urandom), 1'b1, acc);
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2)      op = 3'd0;
      else if (r < 5) op = 3'd1;
      else if (r < 8) op = 3'd2;
      else            op = 3'(3 + $urandom_range(0, 4));
      issue(op, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), acc);
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    wait_idle();
    sweep();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Upstream control stage for the 4-bit ALU (ALUopcode[2:0], v1, v2 -> out).
- Accepts one instruction at a time over a valid/ready handshake and reads two operands from an internal 16x4 register file.
- Drives the ALU inputs, captures the ALU result and writes it back to a destination register.
- Provides a combinational debug read port for the board display logic.

Parameters:
- DATA_W, 4, operand/result width; must match the ALU width.
- ADDR_W, 4, register-file address width.
- DEPTH, 16, number of registers (2**ADDR_W).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- instr_valid  in  1  instruction presented.
- instr  in  15  [14:12] op, [11:8] dst, [7:4] srcA, [3:0] srcB/imm.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- alu_op  out  3  to ALUopcode.
- alu_v1  out  DATA_W  to ALU v1; holds regfile[srcA].
- alu_v2  out  DATA_W  to ALU v2; holds regfile[srcB].
- alu_out  in  DATA_W  from ALU out.
- done  out  1  one-cycle pulse when the write-back completes.
- illegal  out  1  one-cycle pulse when an unsupported opcode is rejected.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  regfile[dbg_addr], combinational.

Behaviour:
- Fixed decision: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values:
  - state=IDLE, instr_ready=1, alu_op=000, alu_v1=0, alu_v2=0.
  - done=0, illegal=0, all registers=0, latched instruction fields=0.
- Opcodes:
  - 000 LDI: regfile[dst] <= imm (instr[3:0]); ALU not used.
  - 001 SUB: regfile[dst] <= alu_out = v2 - v1 = regfile[srcB] - regfile[srcA].
  - 010 ADD: regfile[dst] <= regfile[srcA] + regfile[srcB].
  - 011..111 illegal: ascend/descend are not handled by this stage.
- Arithmetic: modulo 2**DATA_W, no carry or borrow flags.
- FSM states: IDLE, READ, EXEC, WRITE, ERR.
  - IDLE: instr_ready=1. On instr_valid, latch the instr fields; go to READ for legal opcodes, ERR otherwise. instr is ignored without instr_valid.
  - READ: alu_v1 <= regfile[srcA], alu_v2 <= regfile[srcB]; go to EXEC.
  - EXEC: alu_op = latched op (000 in every other state). result <= alu_out, or <= imm for LDI; go to WRITE.
  - WRITE: regfile[dst] <= result at the clock edge that leaves WRITE. done=1 during WRITE; go to IDLE.
  - ERR: illegal=1 for this single cycle; no register write, no done; go to IDLE.
- Latency and throughput:
  - Legal instruction: accept edge to write edge is 3 cycles.
  - Next accept can occur 4 cycles after the previous one, so peak throughput is 1 instruction per 4 cycles.
- Boundary conditions:
  - srcA==srcB is allowed.
  - dst equal to a source is allowed: reads complete in READ, before the write.
  - instr_valid held high after done: the next instruction is accepted in the following IDLE cycle.
  - dbg_data reflects a write from the cycle after the WRITE edge.
  - Reset asserted in any state aborts immediately: no partial write, done and illegal forced to 0, registers cleared.
  - dbg_addr is always in range (DEPTH = 2**ADDR_W).

Decomposition:
- Package seq_pkg:
  - opcode enum: OP_LDI=3'b000, OP_SUB=3'b001, OP_ADD=3'b010.
  - state enum.
  - instruction field bit positions.
  - DATA_W and ADDR_W defaults.
- Sub-module reg_file:
  - DEPTH x DATA_W storage.
  - Two combinational read ports (A, B), one combinational debug read port.
  - One synchronous write port with write enable.
  - Asynchronous active-high clear.
- The ALU is instantiated outside the sequencer, at the top level.

Test Plan:
- Reset mid-EXEC of an ADD -> in the next cycle: state IDLE, instr_ready=1, all dbg_data reads 0, no done pulse.
- LDI r1=3, then LDI r2=5 -> dbg_addr=1 gives 3 and dbg_addr=2 gives 5; done pulses once per instruction, 3 cycles after each accept.
- With r1=3, r2=5: SUB dst=4, srcA=2, srcB=1 -> r4 = 3-5 = 4'b1110; alu_op=001 only in EXEC; alu_v1=5, alu_v2=3.
- With r1=9, r2=8: ADD dst=1, srcA=1, srcB=2 -> r1 = 4'b0001 (wrap); both reads use the old value 9.
- Opcode 011 with instr_valid=1 -> illegal pulses for 1 cycle, no done, all registers unchanged, instr_ready returns high after 2 cycles.
- instr_valid held high with 3 queued LDIs -> accepts spaced exactly 4 cycles apart; instr_ready low in READ, EXEC and WRITE.
